// File: rtl/tft_stream_arbiter.sv
// rtl/tft_stream_arbiter.sv - grants the single tft_spi transmitter to one of N_CH drawing clients
// and muxes the granted client's byte, dc and transmit strobe onto the SPI inputs.
module tft_stream_arbiter #(
  parameter int N_CH     = 4,
  parameter int IDX_W    = 2,
  parameter int DATA_W   = 8,
  parameter int RR       = 1,
  parameter int SEQ_ONCE = 0,
  parameter int START_TO = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_busy,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_dc,
  input  logic [N_CH-1:0]          ch_transmit,
  input  logic                     spi_busy,
  output logic [N_CH-1:0]          ch_enable,
  output logic [DATA_W-1:0]        spi_data,
  output logic                     spi_dc,
  output logic                     spi_transmit,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     active,
  output logic                     timeout_err,
  output logic                     all_done
);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, RELEASE} state_t;

  localparam logic [7:0] TO_LIM = 8'(START_TO);

  state_t            state, state_next;
  logic [7:0]        timer;
  logic [N_CH-1:0]   served;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   win_onehot;
  logic [IDX_W-1:0]  win;
  logic              win_found;
  logic              timed_out;
  logic              g_busy;
  int                cand;

  assign eligible = ch_req & ~served;
  assign g_busy   = ch_busy[grant_idx];
  assign active   = (state == GRANT) || (state == RUN);

  // Round-robin scans upward from the channel after the last grant, wrapping at N_CH.
  always_comb begin
    win        = '0;
    win_onehot = '0;
    win_found  = 1'b0;
    cand       = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (RR != 0) ? (int'(grant_idx) + 1 + k) % N_CH : k;
      if (!win_found && eligible[cand]) begin
        win_found        = 1'b1;
        win              = IDX_W'(cand);
        win_onehot[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    timed_out  = 1'b0;
    case (state)
      IDLE:    if (win_found) state_next = GRANT;
      GRANT: begin
        if (g_busy) begin
          state_next = RUN;
        end else if (timer == TO_LIM) begin
          state_next = RELEASE;
          timed_out  = 1'b1;
        end
      end
      RUN:     if (!g_busy && !spi_busy) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch_enable   <= '0;
      grant_idx   <= IDX_W'(N_CH - 1);
      served      <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      state       <= state_next;
      timeout_err <= timed_out;
      all_done    <= (SEQ_ONCE != 0) && (&served);
      if (state == IDLE && win_found) begin
        grant_idx <= win;
        ch_enable <= win_onehot;
        timer     <= '0;
      end
      if (state == GRANT && !g_busy && timer != 8'hFF)
        timer <= timer + 8'd1;
      if (state_next == RELEASE)
        ch_enable <= '0;
      if (state == RELEASE && SEQ_ONCE != 0)
        served[grant_idx] <= 1'b1;
    end
  end

  // Only the granted channel ever reaches the transmitter; nothing passes while not active.
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    if (active) begin
      spi_data     = ch_data[int'(grant_idx)*DATA_W +: DATA_W];
      spi_dc       = ch_dc[grant_idx];
      spi_transmit = ch_transmit[grant_idx];
    end
  end

endmodule

// File: tb/tb_tft_stream_arbiter.sv
// tb/tb_tft_stream_arbiter.sv - directed bench: round-robin, fixed priority, serve-once,
// start timeout, spi_busy hold and asynchronous reset of tft_stream_arbiter.
module tb_tft_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  req_all, busy_all;
  logic [23:0] data;
  logic [2:0]  dc, tx;
  logic        spi_busy;

  logic [2:0] en_a, en_b, en_c;
  logic [7:0] sd_a, sd_b, sd_c;
  logic       sdc_a, sdc_b, sdc_c, stx_a, stx_b, stx_c;
  logic [1:0] gi_a, gi_b, gi_c;
  logic       act_a, act_b, act_c, to_a, to_b, to_c, ad_a, ad_b, ad_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tft_stream_arbiter #(.N_CH(3), .IDX_W(2), .DATA_W(8), .RR(1), .SEQ_ONCE(0), .START_TO(4)) dut_a (
    .clk(clk), .rst(rst), .ch_req(req_all[2:0]), .ch_busy(busy_all[2:0]), .ch_data(data),
    .ch_dc(dc), .ch_transmit(tx), .spi_busy(spi_busy), .ch_enable(en_a), .spi_data(sd_a),
    .spi_dc(sdc_a), .spi_transmit(stx_a), .grant_idx(gi_a), .active(act_a),
    .timeout_err(to_a), .all_done(ad_a));

  tft_stream_arbiter #(.N_CH(3), .IDX_W(2), .DATA_W(8), .RR(0), .SEQ_ONCE(0), .START_TO(15)) dut_b (
    .clk(clk), .rst(rst), .ch_req(req_all[5:3]), .ch_busy(busy_all[5:3]), .ch_data(data),
    .ch_dc(dc), .ch_transmit(tx), .spi_busy(spi_busy), .ch_enable(en_b), .spi_data(sd_b),
    .spi_dc(sdc_b), .spi_transmit(stx_b), .grant_idx(gi_b), .active(act_b),
    .timeout_err(to_b), .all_done(ad_b));

  tft_stream_arbiter #(.N_CH(3), .IDX_W(2), .DATA_W(8), .RR(1), .SEQ_ONCE(1), .START_TO(15)) dut_c (
    .clk(clk), .rst(rst), .ch_req(req_all[8:6]), .ch_busy(busy_all[8:6]), .ch_data(data),
    .ch_dc(dc), .ch_transmit(tx), .spi_busy(spi_busy), .ch_enable(en_c), .spi_data(sd_c),
    .spi_dc(sdc_c), .spi_transmit(stx_c), .grant_idx(gi_c), .active(act_c),
    .timeout_err(to_c), .all_done(ad_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] en_of(input int d);
    case (d)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  // Waits (bounded) for any enable of dut d; checks the idle gap and which channel won.
  task automatic wait_grant(input int d, input int k, input int exp_gap, input string tag);
    int n;
    n = 0;
    while (en_of(d) == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gap"}, n, exp_gap);
    check({tag, "_en"}, en_of(d), 32'(1 << k));
  endtask

  task automatic finish_client(input int d, input int k, input int nbusy, input string tag);
    busy_all[d*3+k] = 1'b1;
    repeat (nbusy) @(negedge clk);
    busy_all[d*3+k] = 1'b0;
    @(negedge clk);
    check({tag, "_fall"}, en_of(d), 0);
  endtask

  task automatic serve(input int d, input int k, input int nbusy, input int exp_gap, input string tag);
    wait_grant(d, k, exp_gap, tag);
    finish_client(d, k, nbusy, tag);
  endtask

  initial begin
    int cnt;
    logic [2:0] seen;
    rst = 1'b1; req_all = '0; busy_all = '0; spi_busy = 1'b0;
    data = {8'h3C, 8'h5A, 8'hA5}; dc = 3'b001; tx = 3'b110;
    repeat (2) @(negedge clk);
    check("rst_en", en_a, 0);
    check("rst_gidx", gi_a, 2);
    check("rst_active", act_a, 0);
    check("rst_data", sd_a, 0);
    check("rst_done", ad_c, 0);
    rst = 1'b0;

    // Round-robin order 0,1,2,0 with one IDLE cycle between grants
    req_all[2:0] = 3'b111;
    serve(0, 0, 5, 1, "rr0");
    serve(0, 1, 5, 2, "rr1");
    serve(0, 2, 5, 2, "rr2");
    serve(0, 0, 5, 2, "rr3");
    req_all[2:0] = 3'b000;

    // Start timeout: channel 1 never goes busy
    @(negedge clk);
    req_all[2:0] = 3'b010;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en_a[1]) cnt++;
      else if (cnt > 0) break;
    end
    check("to_len", cnt, 5);
    check("to_pulse", to_a, 1);
    req_all[2:0] = 3'b000;
    @(negedge clk);
    check("to_pulse_end", to_a, 0);

    // spi_busy holds the grant after the client drops busy
    req_all[2:0] = 3'b001;
    wait_grant(0, 0, 1, "sb");
    req_all[2:0] = 3'b000;
    check("sb_data", sd_a, 32'hA5);
    check("sb_dc", sdc_a, 1);
    check("sb_tx_blocked", stx_a, 0);
    tx = 3'b001;
    busy_all[0] = 1'b1; spi_busy = 1'b1;
    @(negedge clk);
    check("sb_tx", stx_a, 1);
    @(negedge clk);
    busy_all[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sb_hold_en", en_a, 3'b001);
      check("sb_hold_data", sd_a, 32'hA5);
    end
    spi_busy = 1'b0;
    @(negedge clk);
    check("sb_fall", en_a, 0);
    check("sb_idle_data", sd_a, 0);
    check("sb_idle_tx", stx_a, 0);

    // Fixed priority: 1 starves 2, then 0 preempts on the next grant
    req_all[5:3] = 3'b110;
    serve(1, 1, 3, 1, "fp0");
    serve(1, 1, 3, 2, "fp1");
    wait_grant(1, 1, 2, "fp2");
    busy_all[4] = 1'b1;
    @(negedge clk);
    req_all[5:3] = 3'b111;
    repeat (2) @(negedge clk);
    busy_all[4] = 1'b0;
    @(negedge clk);
    check("fp2_fall", en_b, 0);
    serve(1, 0, 3, 2, "fp3");
    req_all[5:3] = 3'b000;

    // Serve-once sequencing
    req_all[8:6] = 3'b111;
    serve(2, 0, 4, 1, "sq0");
    serve(2, 1, 4, 2, "sq1");
    serve(2, 2, 4, 2, "sq2");
    check("sq_done_e0", ad_c, 0);
    @(negedge clk);
    check("sq_done_e1", ad_c, 0);
    @(negedge clk);
    check("sq_done_e2", ad_c, 1);
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen |= en_c;
    end
    check("sq_no_more", seen, 0);
    req_all[8:6] = 3'b000;

    // Asynchronous reset mid-RUN, then channel 0 wins first again
    req_all[2:0] = 3'b001;
    wait_grant(0, 0, 1, "ar");
    busy_all[0] = 1'b1; req_all[2:0] = 3'b000;
    @(negedge clk);
    check("ar_tx_pre", stx_a, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_en", en_a, 0);
    check("ar_tx", stx_a, 0);
    check("ar_active", act_a, 0);
    check("ar_gidx", gi_a, 2);
    check("ar_done", ad_c, 0);
    @(negedge clk);
    rst = 1'b0; busy_all = '0; req_all[2:0] = 3'b011;
    serve(0, 0, 2, 1, "ar_next");
    req_all = '0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tft_stream_arbiter.md
Name: tft_stream_arbiter

Overview:
- Parametrised successor to the hard-wired init/scene/player enable chain in the display top level.
- Grants exclusive access to the single tft_spi transmitter to one of N_CH drawing clients (tft_init, scene_exhibitor, player, ...).
- Multiplexes the granted client's data/dc/transmit onto the SPI inputs.
- Adds round-robin or fixed priority, request-driven grants, a start timeout, and optional serve-once sequencing.

Parameters:
- N_CH, 4, number of client channels (2..8).
- IDX_W, 2, grant index width; must be >= clog2(N_CH).
- DATA_W, 8, SPI data byte width.
- RR, 1, 1 = round-robin priority, 0 = fixed priority (lowest index wins).
- SEQ_ONCE, 0, 1 = each channel is served at most once after reset.
- START_TO, 15, maximum cycles in GRANT waiting for the client's busy before forced release (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_req  in  N_CH  per-channel access request (level).
- ch_busy  in  N_CH  per-channel busy from the client.
- ch_data  in  N_CH*DATA_W  client bytes, channel k at bits [k*DATA_W +: DATA_W].
- ch_dc  in  N_CH  client data/command select.
- ch_transmit  in  N_CH  client transmit strobe.
- spi_busy  in  1  busy from tft_spi.
- ch_enable  out  N_CH  one-hot grant, at most one bit set.
- spi_data  out  DATA_W  muxed byte to tft_spi.
- spi_dc  out  1  muxed dc.
- spi_transmit  out  1  muxed transmit.
- grant_idx  out  IDX_W  index of the current or last granted channel.
- active  out  1  high in GRANT or RUN.
- timeout_err  out  1  one-cycle pulse on forced release.
- all_done  out  1  SEQ_ONCE=1: all channels served; tied 0 otherwise.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ch_enable=0; grant_idx=N_CH-1 (so channel 0 wins first in RR mode).
  - served mask=0; timer=0; timeout_err=0; all_done=0.
  - Mux outputs are 0 because no grant is active.
  - Reset mid-transfer drops the grant the same instant; the in-flight SPI byte is abandoned.
- Eligible set: ch_req & ~served (served is always 0 when SEQ_ONCE=0).
- IDLE:
  - If the eligible set is non-zero, pick winner w and register grant_idx=w, ch_enable=one-hot(w), timer=0, then go to GRANT.
  - Winner in RR mode: first eligible index scanning upward from grant_idx+1, wrapping modulo N_CH.
  - Winner in fixed mode: lowest eligible index.
  - Grant latency: request seen at cycle t -> ch_enable at t+1.
- GRANT:
  - ch_busy[w]=1 -> go to RUN.
  - Otherwise timer increments; when timer == START_TO and busy is still 0 -> RELEASE with timeout_err=1 for one cycle.
- RUN:
  - Go to RELEASE when ch_busy[w]==0 AND spi_busy==0 in the same cycle. This guarantees the last byte has been shifted out.
  - ch_req changes during RUN are ignored.
- RELEASE (one cycle):
  - ch_enable=0.
  - If SEQ_ONCE, set served[w] (including on timeout).
  - Next state is IDLE. There is always at least one idle cycle between grants, so a client never sees enable re-asserted back-to-back.
- Mux:
  - Combinational from registered grant_idx, qualified by active.
  - active=0 -> spi_data=0, spi_dc=0, spi_transmit=0.
  - Non-granted channels' transmit is never passed through.
- all_done: registered; rises the cycle after the final served bit is set; stays high until reset.
- Simultaneous events:
  - Multiple requests in the same cycle are resolved by the priority rule only.
  - A request that drops during GRANT does not abort the grant; only busy or timeout ends it.
- Width rules:
  - grant_idx+1 wraps modulo N_CH, not modulo 2^IDX_W.
  - The timer saturates and never wraps.

Test Plan:
- N_CH=3, RR=1, ch_req=3'b111 held, each client busy for 5 cycles after enable -> grant order 0,1,2,0. Each ch_enable falls one cycle after its busy falls, with exactly one idle cycle between grants.
- RR=0, ch_req=3'b110 held -> channel 1 is granted every time and channel 2 never is (starvation by design). Then raise ch_req[0] during channel 1's RUN -> channel 0 wins the next grant.
- SEQ_ONCE=1, requests 3'b111 held, mimicking init/scene/player -> serve order 0,1,2 once each. all_done=1 two cycles after channel 2's enable falls; no further grants.
- START_TO=4, channel 1 requests but never asserts busy -> ch_enable[1] for 5 cycles, then a timeout_err pulse, then release. Next grant proceeds normally.
- Channel 0 in RUN with busy=0 but spi_busy=1 for 3 more cycles -> enable is held until spi_busy falls. spi_data/dc/transmit track channel 0 throughout.
- Assert rst for 1 cycle mid-RUN -> ch_enable, spi_transmit and active drop asynchronously. After release, channel 0 is granted first again.
